// File: rtl/my_srl_chain.sv
// CE-gated shift chain with a dynamic read tap: the parametrised successor of SRL16E.
// No reset; contents only move when CE is high.
module my_srl_chain #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (CE) begin
      sr_q[0] <= D;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign Q = sr_q[A];

endmodule

// File: rtl/my_srl_fifo.sv
// SRL-style synchronous FIFO: shift chain storage, show-ahead read at COUNT-1,
// valid/ready handshake on both sides, occupancy count and almost-full flag.
module my_srl_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic [WIDTH-1:0]           S_DATA,
  input  logic                       S_VALID,
  output logic                       S_READY,
  output logic [WIDTH-1:0]           M_DATA,
  output logic                       M_VALID,
  input  logic                       M_READY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       ALMOST_FULL
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH+1);
  localparam int unsigned AF_TH = DEPTH - AF_MARGIN;

  logic [CW-1:0] count_q, count_d;
  logic          rstn_q;
  logic          push, pop;
  logic          chain_ce;
  logic [AW-1:0] ptr;

  assign M_VALID     = (count_q != '0);
  assign S_READY     = rstn_q & (count_q != CW'(DEPTH));
  assign push        = S_VALID & S_READY;
  assign pop         = M_VALID & M_READY;
  assign COUNT       = count_q;
  assign ALMOST_FULL = (count_q >= CW'(AF_TH));

  // Reset discards a coinciding push; storage itself is never cleared.
  assign chain_ce = push & RSTN;

  // Oldest word sits at COUNT-1; on push+pop the chain shifts under a held pointer.
  assign ptr = AW'(count_q - CW'(1));

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    rstn_q <= RSTN;
    if (!RSTN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  my_srl_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_chain (
    .CLK (CLK),
    .CE  (chain_ce),
    .D   (S_DATA),
    .A   (ptr),
    .Q   (M_DATA)
  );

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
    !(push && !pop && count_q == CW'(DEPTH)));

  a_no_underflow: assert property (@(posedge CLK) disable iff (!RSTN)
    !(pop && !push && count_q == '0));

  a_count_range: assert property (@(posedge CLK) disable iff (!RSTN)
    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_my_srl_fifo.sv
// Scoreboard bench for my_srl_fifo: a queue reference model advanced on each posedge,
// a negedge monitor comparing every visible output, plus directed and random stimulus.
module tb_my_srl_fifo;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned AF_MARGIN = 2;
  localparam int unsigned CW        = $clog2(DEPTH+1);

  logic             clk;
  logic             rstn;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [CW-1:0]    count;
  logic             almost_full;

  my_srl_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .CLK         (clk),
    .RSTN        (rstn),
    .S_DATA      (s_data),
    .S_VALID     (s_valid),
    .S_READY     (s_ready),
    .M_DATA      (m_data),
    .M_VALID     (m_valid),
    .M_READY     (m_ready),
    .COUNT       (count),
    .ALMOST_FULL (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of stored words, oldest at the front.
  logic [WIDTH-1:0] exp_q[$];
  bit               ready_ok = 1'b0;
  bit               armed    = 1'b0;

  always @(posedge clk) begin
    bit acc, rd;
    if (!rstn) begin
      exp_q.delete();
      ready_ok = 1'b0;
      armed    = 1'b1;
    end else begin
      acc = s_valid && ready_ok && (exp_q.size() < DEPTH);
      rd  = m_ready && (exp_q.size() > 0);
      if (rd)  void'(exp_q.pop_front());
      if (acc) exp_q.push_back(s_data);
      ready_ok = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("count",       32'(count),       32'(exp_q.size()));
      chk("m_valid",     32'(m_valid),     32'(exp_q.size() > 0));
      chk("s_ready",     32'(s_ready),     32'(ready_ok && exp_q.size() < DEPTH));
      chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= DEPTH - AF_MARGIN));
      if (exp_q.size() > 0) chk("m_data", 32'(m_data), 32'(exp_q[0]));
    end
  end

  task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit r);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("reset_count",  32'(count),   32'd0);
    chk("reset_sready", 32'(s_ready), 32'd0);
    cyc(0, 8'h00, 0);
    chk("ready_after_reset", 32'(s_ready), 32'd1);

    // Three pushes, then drain in order
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
    s_valid = 1'b0;
    chk("t1_count", 32'(count),  32'd3);
    chk("t1_head",  32'(m_data), 32'h11);
    cyc(0, 8'h00, 1); cyc(0, 8'h00, 1); cyc(0, 8'h00, 1);
    chk("t1_empty", 32'(m_valid), 32'd0);

    // Fill to full, then an ignored extra push
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 0);
    chk("t2_full_count",  32'(count),       32'd16);
    chk("t2_full_sready", 32'(s_ready),     32'd0);
    chk("t2_af",          32'(almost_full), 32'd1);
    cyc(1, 8'hEE, 0);
    chk("t2_ignored_count", 32'(count),  32'd16);
    chk("t2_head_kept",     32'(m_data), 32'h40);

    // Full with coincident pop and push: the push is refused
    cyc(1, 8'h99, 1);
    chk("t4_count",  32'(count),   32'd15);
    chk("t4_sready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 10; i++) cyc(0, 8'h00, 1);

    // Streaming at constant occupancy 5
    for (int i = 0; i < 100; i++) cyc(1, 8'(i), 1);
    chk("t3_count", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1);

    // Pops on empty are ignored; single-cycle write-to-read latency
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
    chk("t5_count", 32'(count), 32'd0);
    cyc(1, 8'hA5, 0);
    s_valid = 1'b0;
    chk("t5_valid", 32'(m_valid), 32'd1);
    chk("t5_data",  32'(m_data),  32'hA5);
    cyc(0, 8'h00, 1);

    // Mid-operation reset with push and pop active
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'hC0 + i), 0);
    chk("t6_pre_count", 32'(count), 32'd9);
    rstn = 1'b0;
    cyc(1, 8'h77, 1);
    rstn = 1'b1;
    chk("t6_count",  32'(count),   32'd0);
    chk("t6_valid",  32'(m_valid), 32'd0);
    chk("t6_sready", 32'(s_ready), 32'd0);
    cyc(0, 8'h00, 0);
    chk("t6_sready_back", 32'(s_ready), 32'd1);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rstn = ($urandom_range(0, 99) != 0);
      cyc(bit'($urandom_range(0, 3) != 0), 8'($urandom), bit'($urandom_range(0, 2) == 0));
    end
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) cyc(0, 8'h00, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
